fir_4_tap_bank: RTL and testbench

//  Cascadable 4-tap FIR slice: 4-deep sample delay line plus multiply-accumulate of four coefficients.

---
 rtl/fir_4_tap_bank.sv | 98 +++++++++
 tb/tb_fir_4_tap_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_4_tap_bank.sv
// fir_4_tap_bank
//   One slice of a cascadable FIR filter: a 4-deep sample delay line plus a
//   multiply-accumulate of four signed Q2.15 coefficients. Eight slices chained
//   sample_out -> sample_in form a seamless 32-tap line; partial sums may also
//   be cascaded through acc_in -> acc_out.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears taps and outputs
//   enable     in   one-cycle strobe per new audio sample
//   sample_in  in   signed new sample (or upstream slice's sample_out)
//   coeff1..4  in   signed coefficients for newest .. oldest tap of the window
//   acc_in     in   signed partial sum from upstream (tie to 0 if unused)
//   sample_out out  registered oldest sample (d3), feeds the next slice
//   acc_out    out  registered acc_in + this slice's scaled dot product
//
// Handshake: there is no valid/ready pair. A rising edge with enable=1 is the
// only event that moves data; it shifts the line and captures a new acc_out,
// both visible the cycle after the edge. With enable=0 every register holds
// and acc_in, sample_in and the coefficients are ignored. No input reaches an
// output combinationally.

module fir_4_tap_bank #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 17,
  parameter int FRAC_BITS = 15,
  parameter bit SATURATE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic [COEFF_W-1:0] coeff1,
  input  logic [COEFF_W-1:0] coeff2,
  input  logic [COEFF_W-1:0] coeff3,
  input  logic [COEFF_W-1:0] coeff4,
  input  logic [DATA_W-1:0]  acc_in,
  output logic [DATA_W-1:0]  sample_out,
  output logic [DATA_W-1:0]  acc_out
);

  localparam int PROD_W = DATA_W + COEFF_W;  // full signed product
  localparam int SUM_W  = PROD_W + 2;        // four products cannot overflow
  localparam int ACC_W  = SUM_W + 1;         // shifted sum plus acc_in

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] d0, d1, d2, d3;

  logic signed [PROD_W-1:0] prod1, prod2, prod3, prod4;
  logic signed [SUM_W-1:0]  p_sum;
  logic signed [SUM_W-1:0]  p_scaled;
  logic signed [ACC_W-1:0]  acc_full;
  logic [DATA_W-1:0]        acc_next;

  // The window multiplied here is the one that exists after the shift:
  // sample_in is the newest tap and d0..d2 the three older ones.
  always_comb begin
    prod1    = $signed(sample_in) * $signed(coeff1);
    prod2    = $signed(d0)        * $signed(coeff2);
    prod3    = $signed(d1)        * $signed(coeff3);
    prod4    = $signed(d2)        * $signed(coeff4);
    p_sum    = SUM_W'(prod1) + SUM_W'(prod2) + SUM_W'(prod3) + SUM_W'(prod4);
    // Arithmetic shift floors toward -inf; scaling happens before acc_in joins.
    p_scaled = p_sum >>> FRAC_BITS;
    acc_full = ACC_W'(p_scaled) + ACC_W'($signed(acc_in));
    acc_next = acc_full[DATA_W-1:0];
    if (SATURATE) begin
      if (acc_full > ACC_MAX) begin
        acc_next = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (acc_full < ACC_MIN) begin
        acc_next = {1'b1, {(DATA_W-1){1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      d3      <= '0;
      acc_out <= '0;
    end else if (enable) begin
      d0      <= sample_in;
      d1      <= d0;
      d2      <= d1;
      d3      <= d2;
      acc_out <= acc_next;
    end
  end

  assign sample_out = d3;

endmodule

// File: tb/tb_fir_4_tap_bank.sv
module tb_fir_4_tap_bank;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] sample_in;
  logic [16:0] coeff1, coeff2, coeff3, coeff4;
  logic [15:0] acc_in;
  logic [15:0] a_sample_out, a_acc_out;
  logic [15:0] b_sample_out, b_acc_out;
  logic [15:0] w_sample_out, w_acc_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  // Slice A (saturating), slice B chained behind A, slice W = A with wrapping.
  fir_4_tap_bank u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3), .coeff4(coeff4),
    .acc_in(acc_in), .sample_out(a_sample_out), .acc_out(a_acc_out)
  );

  fir_4_tap_bank u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(a_sample_out),
    .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3), .coeff4(coeff4),
    .acc_in(16'd0), .sample_out(b_sample_out), .acc_out(b_acc_out)
  );

  fir_4_tap_bank #(.SATURATE(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3), .coeff4(coeff4),
    .acc_in(acc_in), .sample_out(w_sample_out), .acc_out(w_acc_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // ---------------- model ----------------
  // The A/B pair is one 8-deep history of samples entered into A, newest at
  // index 0. A's window is sample_in + hist[0..2]; B's window is hist[3..6].
  longint hist[8] = '{default: 0};
  longint ea_raw  = 0;
  longint eb_raw  = 0;

  function automatic longint dot(longint s0, longint s1, longint s2, longint s3);
    longint p;
    p = longint'($signed(coeff1)) * s0 + longint'($signed(coeff2)) * s1 +
        longint'($signed(coeff3)) * s2 + longint'($signed(coeff4)) * s3;
    return p >>> 15;
  endfunction

  function automatic logic [15:0] fit(longint v, bit sat);
    logic [63:0] u;
    if (sat) begin
      if (v > 32767)  return 16'h7fff;
      if (v < -32768) return 16'h8000;
    end
    u = 64'(v);
    return u[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] <= 0;
      ea_raw <= 0;
      eb_raw <= 0;
    end else if (enable) begin
      ea_raw  <= dot(longint'($signed(sample_in)), hist[0], hist[1], hist[2]) +
                 longint'($signed(acc_in));
      eb_raw  <= dot(hist[3], hist[4], hist[5], hist[6]);
      hist[0] <= longint'($signed(sample_in));
      for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      check("model a_acc", a_acc_out,    fit(ea_raw, 1'b1));
      check("model a_so",  a_sample_out, fit(hist[3], 1'b1));
      check("model b_acc", b_acc_out,    fit(eb_raw, 1'b1));
      check("model b_so",  b_sample_out, fit(hist[7], 1'b1));
      check("model w_acc", w_acc_out,    fit(ea_raw, 1'b0));
      check("model w_so",  w_sample_out, fit(hist[3], 1'b1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_enable(input logic [15:0] s);
    @(negedge clk);
    sample_in = s;
    enable    = 1'b1;
    @(negedge clk);
    enable    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_coeffs(input logic [16:0] c1, input logic [16:0] c2,
                            input logic [16:0] c3, input logic [16:0] c4);
    coeff1 = c1;
    coeff2 = c2;
    coeff3 = c3;
    coeff4 = c4;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    sample_in = '0;
    acc_in    = '0;
    set_coeffs(17'd0, 17'd0, 17'd0, 17'd0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset a_acc", a_acc_out, 16'd0);
    check("reset a_so",  a_sample_out, 16'd0);
    check("reset b_acc", b_acc_out, 16'd0);
    rst_n = 1'b1;

    // Impulse response with a hold interval after the first sample.
    set_coeffs(17'd16384, 17'd8192, -17'sd8192, 17'd32768);
    acc_in = 16'd0;
    do_enable(16'd1000);
    check("impulse step1 acc", a_acc_out, 16'd500);
    check("impulse step1 so",  a_sample_out, 16'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_in = 16'($urandom_range(0, 65535));
      acc_in    = 16'($urandom_range(0, 65535));
    end
    @(negedge clk);
    check("hold acc", a_acc_out, 16'd500);
    check("hold so",  a_sample_out, 16'd0);
    acc_in = 16'd0;
    exp_q = {16'd250, 16'hff06, 16'd1000, 16'd0};
    for (int i = 0; i < 4; i++) begin
      do_enable(16'd0);
      check("impulse acc", a_acc_out, exp_q.pop_front());
      check("impulse so",  a_sample_out, (i == 2) ? 16'd1000 : 16'd0);
    end

    // Pass-through and floor rounding.
    do_reset();
    set_coeffs(17'd0, 17'd0, 17'd0, 17'd0);
    acc_in = 16'hff85;  // -123
    do_enable(16'd0);
    check("pass acc_in", a_acc_out, 16'hff85);
    acc_in = 16'd0;
    set_coeffs(17'd1, 17'd0, 17'd0, 17'd0);
    do_enable(16'hffff);
    check("floor neg", a_acc_out, 16'hffff);
    do_enable(16'd1);
    check("floor pos", a_acc_out, 16'd0);

    // Saturation and wrap.
    do_reset();
    set_coeffs(17'd32768, 17'd32768, 17'd32768, 17'd32768);
    for (int i = 0; i < 4; i++) do_enable(16'd32767);
    check("sat pos",  a_acc_out, 16'h7fff);
    check("wrap pos", w_acc_out, 16'hfffc);
    do_reset();
    for (int i = 0; i < 4; i++) do_enable(16'h8000);
    check("sat neg",  a_acc_out, 16'h8000);
    check("wrap neg", w_acc_out, 16'd0);

    // Two-slice chain: the impulse reaches B on enables 5..8.
    do_reset();
    do_enable(16'd1000);
    for (int k = 2; k <= 9; k++) begin
      do_enable(16'd0);
      if (k >= 5) check("chain b_acc", b_acc_out, (k <= 8) ? 16'd1000 : 16'd0);
    end

    // Async reset between clock edges.
    do_enable(16'd1000);
    check("pre-reset a_acc", a_acc_out, 16'd1000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async a_acc", a_acc_out, 16'd0);
    check("async a_so",  a_sample_out, 16'd0);
    check("async b_acc", b_acc_out, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_coeffs(17'd16384, 17'd32768, 17'd32768, 17'd32768);
    do_enable(16'd200);
    check("post-reset acc", a_acc_out, 16'd100);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
